// File: rtl/uart_rx_pkg.sv
// Shared UART receive constants, FSM state type and small bit-level helpers.
package uart_rx_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int PRESCALE_W = 6;
    localparam int BIT_CNT_W  = $clog2(DATA_WIDTH);

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Only 16 and 32 are honoured; every other ratio falls back to 8.
    function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
        case (p)
            PRESCALE_W'(16): return PRESCALE_W'(16);
            PRESCALE_W'(32): return PRESCALE_W'(32);
            default:         return PRESCALE_W'(8);
        endcase
    endfunction

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and received-data outputs of the UART receiver.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, par_err, stp_err
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with 3-sample mid-bit majority vote and an end-of-bit pulse.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_i,
    input  logic                  start_i,
    input  logic                  run_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  bit_val_o,
    output logic                  bit_done_o
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] half, last;
    logic [2:0]            samples_q;
    logic                  bit_val_q;
    logic                  bit_done_q;

    assign half = prescale_i >> 1;
    assign last = prescale_i - PRESCALE_W'(1);

    // Next edge count; the start-detect cycle is edge 0, so the following cycle is edge 1.
    always_comb begin
        edge_cnt_d = '0;
        if (start_i) begin
            edge_cnt_d = PRESCALE_W'(1);
        end else if (run_i) begin
            if (edge_cnt_q == last) begin
                edge_cnt_d = '0;
            end else begin
                edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
            end
        end else begin
            edge_cnt_d = '0;
        end
    end

    // Counter, sample capture, vote and a bit_done registered one cycle ahead of edge P-1.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            samples_q  <= 3'b000;
            bit_val_q  <= 1'b0;
            bit_done_q <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_done_q <= run_i && (edge_cnt_d == last);
            if (run_i) begin
                if (edge_cnt_q == half - PRESCALE_W'(1)) begin
                    samples_q[0] <= rx_i;
                end else if (edge_cnt_q == half) begin
                    samples_q[1] <= rx_i;
                end else if (edge_cnt_q == half + PRESCALE_W'(1)) begin
                    samples_q[2] <= rx_i;
                end else if (edge_cnt_q == half + PRESCALE_W'(2)) begin
                    bit_val_q <= majority3(samples_q);
                end
            end
        end
    end

    assign bit_val_o  = bit_val_q;
    assign bit_done_o = bit_done_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserializer, parity/stop checks and result strobes.
module uart_rx
    import uart_rx_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);

    rx_state_t             state_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bad_q;
    logic [PRESCALE_W-1:0] cfg_p_q;
    logic                  cfg_par_en_q;
    logic                  cfg_par_typ_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic detect;
    logic run;
    logic bit_val;
    logic bit_done;

    assign detect = (state_q == IDLE) && !bus.RX_IN;
    assign run    = (state_q != IDLE);

    uart_rx_sampler u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .rx_i       (bus.RX_IN),
        .start_i    (detect),
        .run_i      (run),
        .prescale_i (cfg_p_q),
        .bit_val_o  (bit_val),
        .bit_done_o (bit_done)
    );

    // Frame FSM; strobes default low so each lasts exactly one cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_bad_q     <= 1'b0;
            cfg_p_q       <= PRESCALE_W'(8);
            cfg_par_en_q  <= 1'b0;
            cfg_par_typ_q <= 1'b0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (detect) begin
                        cfg_p_q       <= legal_prescale(bus.Prescale);
                        cfg_par_en_q  <= bus.PAR_EN;
                        cfg_par_typ_q <= bus.PAR_TYP;
                        bit_cnt_q     <= '0;
                        par_bad_q     <= 1'b0;
                        state_q       <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state_q <= bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_q[bit_cnt_q] <= bit_val;
                        if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= cfg_par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        par_bad_q <= bit_val != ((^shift_q) ^ (cfg_par_typ_q == PAR_ODD));
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        stp_err_q <= !bit_val;
                        par_err_q <= par_bad_q;
                        if (bit_val && !par_bad_q) begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shift_q;
                        end
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.Data_Valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frame-level checks of uart_rx against a per-frame outcome model.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_pdata = 8'h00;

    uart_rx_if ifc ();

    uart_rx dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    function automatic int eff_p(input logic [5:0] pre);
        if (pre == 6'd16) return 16;
        if (pre == 6'd32) return 32;
        return 8;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({ifc.Data_Valid, ifc.par_err, ifc.stp_err, ifc.P_DATA});
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.RX_IN = 1'b1;
            @(posedge clk); #1;
            chk("idle_quiet", outs(), 32'({3'b000, exp_pdata}));
        end
    endtask

    // Drives one frame cycle by cycle; flip_cyc inverts one cycle of line level, rst_cyc aborts.
    task automatic send_frame(input logic [7:0] data, input logic [5:0] pre, input logic en,
                              input logic typ, input logic par_force, input logic par_val,
                              input logic stop_val, input int flip_cyc, input int rst_cyc);
        int         p;
        int         nb;
        logic [10:0] fr;
        logic       par_exp;
        logic       par_bit;
        logic       pe;
        logic       se;
        logic       lvl;
        p       = eff_p(pre);
        nb      = en ? 11 : 10;
        par_exp = (^data) ^ typ;
        par_bit = par_force ? par_val : par_exp;
        fr      = 11'h7FF;
        fr[0]   = 1'b0;
        for (int i = 0; i < 8; i++) fr[1+i] = data[i];
        if (en) begin
            fr[9]  = par_bit;
            fr[10] = stop_val;
        end else begin
            fr[9]  = stop_val;
        end
        pe = en && (par_bit != par_exp);
        se = !stop_val;
        ifc.Prescale = pre;
        ifc.PAR_EN   = en;
        ifc.PAR_TYP  = typ;
        for (int c = 0; c < nb * p; c++) begin
            lvl = fr[c / p];
            if (c == flip_cyc) lvl = !lvl;
            ifc.RX_IN = lvl;
            rst_n     = (c == rst_cyc) ? 1'b0 : 1'b1;
            if (c == 1) begin
                ifc.Prescale = 6'($urandom_range(63, 0));
                ifc.PAR_EN   = 1'($urandom);
                ifc.PAR_TYP  = 1'($urandom);
            end
            @(posedge clk); #1;
            if (c == rst_cyc) begin
                rst_n     = 1'b1;
                exp_pdata = 8'h00;
                chk("reset_mid_frame", outs(), 32'h0);
                return;
            end
            if (c == nb * p - 1) begin
                if (!pe && !se) exp_pdata = data;
                chk("frame_result", outs(), 32'({!pe && !se, pe, se, exp_pdata}));
            end else begin
                chk("frame_quiet", outs(), 32'({3'b000, exp_pdata}));
            end
        end
    endtask

    initial begin
        int        sel;
        logic [5:0] pre;
        logic      en;
        logic      typ;
        int        nb;

        rst_n        = 1'b0;
        ifc.RX_IN    = 1'b1;
        ifc.Prescale = 6'd8;
        ifc.PAR_EN   = 1'b0;
        ifc.PAR_TYP  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_state", outs(), 32'h0);
        end
        rst_n = 1'b1;
        idle(4);

        send_frame(8'hA1, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(2);
        send_frame(8'hB2, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
        idle(2);
        send_frame(8'h5C, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(2);

        // Two-cycle low glitch at P=8, then back-to-back frames from cycle 8.
        ifc.Prescale = 6'd8;
        for (int c = 0; c < 8; c++) begin
            ifc.RX_IN = (c < 2) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            chk("glitch_quiet", outs(), 32'({3'b000, exp_pdata}));
        end
        send_frame(8'h3C, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'hC3, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(2);

        send_frame(8'hFF, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 16 + 8, -1);
        idle(2);

        // Break: line held low through two frame times.
        send_frame(8'h00, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        send_frame(8'h00, 6'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        idle(2);

        send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5 * 8 + 4);
        idle(24);
        send_frame(8'h12, 6'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1);
        idle(2);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(3, 0);
            pre = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : (sel == 2) ? 6'd32
                                    : 6'($urandom_range(63, 0));
            en  = 1'($urandom);
            typ = 1'($urandom);
            nb  = en ? 11 : 10;
            send_frame(8'($urandom), pre, en, typ, ($urandom_range(5, 0) == 0), 1'($urandom),
                       ($urandom_range(7, 0) != 0), $urandom_range(nb * eff_p(pre) - 1, 1), -1);
            idle($urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. It is the receive-side counterpart of the uart_tx path (serializer + parity_calc) and recovers the frames that path produces.
- Oversamples RX_IN at Prescale x baud, majority-votes 3 mid-bit samples, and deserializes LSB-first data.
- Checks the optional parity bit and the stop bit, then presents P_DATA with a one-cycle Data_Valid strobe.
- Sits between the RX pin synchronizer and the system-side receive consumer.

Parameters:
- DATA_WIDTH, 8 (from UART_PACKAGE): payload bits per frame.
- PRESCALE_W, 6 (from UART_PACKAGE): width of the Prescale input.

Ports:
- CLK  in  1  oversampling clock (Prescale x baud).
- RST  in  1  reset; synchronous, active-low.
- RX_IN  in  1  serial line, already synchronized; idle high.
- Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd. Same encoding as parity_calc.
- P_DATA  out  DATA_WIDTH  last good payload.
- Data_Valid  out  1  one-cycle strobe marking P_DATA as new.
- par_err  out  1  one-cycle strobe: received parity mismatch.
- stp_err  out  1  one-cycle strobe: stop bit sampled 0.

Behaviour:
Reset
- Sync, active-low: on a CLK edge with RST=0, all outputs go to 0, FSM goes to IDLE, and all counters clear. This applies mid-frame too; the partial frame is discarded with no strobes.

Configuration capture
- Prescale, PAR_EN and PAR_TYP are captured on the start-detect cycle. Changes mid-frame are ignored.
- Any captured Prescale other than 16 or 32 is treated as 8.

Counters
- edge_cnt runs 0..P-1 within each bit period (P = captured prescale).
- bit_cnt runs 0..DATA_WIDTH-1 in DATA.

Sampling
- Samples are taken at edge_cnt = P/2-1, P/2 and P/2+1.
- The bit value is the majority of the three samples, registered at edge_cnt = P/2+2.

FSM states and transitions
- IDLE: when RX_IN=0, move to START. The detect cycle counts as edge 0 of the start bit.
- START: at edge_cnt=P-1:
  - sampled bit 1 → IDLE (glitch). No strobes are raised.
  - otherwise → DATA.
- DATA: the sampled bit is shifted into the shift register at bit position bit_cnt (LSB first). After DATA_WIDTH bits:
  - PAR_EN=1 → PARITY
  - PAR_EN=0 → STOP
- PARITY: expected bit = XOR of data bits (even), inverted if odd. Any mismatch is recorded in a par_bad flag.
- STOP: at edge_cnt=P-1, registered outputs update and the FSM returns to IDLE:
  - stp_err = (stop sample == 0)
  - par_err = par_bad
  - If neither error: Data_Valid=1 and P_DATA = shift register.
  - If either error: Data_Valid=0 and P_DATA is held.

Strobes and latency
- All strobes last exactly one cycle. par_err and stp_err may assert together.
- P_DATA holds its value until the next good frame.
- With N = 1 + DATA_WIDTH + PAR_EN + 1 frame bits and the start-detect cycle as cycle 0, strobes assert in cycle N*P.

Back-to-back frames
- In the strobe cycle the FSM is already in IDLE. RX_IN=0 in that cycle starts the next frame, so no dead cycle is required.

Break / line held low
- Start, data and stop bits all read 0, so stp_err fires.
- The FSM then re-arms in IDLE and immediately detects a new start while the line stays low. One stp_err is raised per N*P cycles.

Decomposition:
UART_PACKAGE
- DATA_WIDTH and PRESCALE_W constants.
- rx_state_t enum: IDLE, START, DATA, PARITY, STOP.
- PAR_EVEN/PAR_ODD constants, shared with parity_calc.

Sub-module
- One natural sub-module, uart_rx_sampler: edge counter, 3-sample majority vote, and bit_done pulse.
- The FSM, deserializer and checks stay in uart_rx.

Test Plan:
- P=8, PAR_EN=1, PAR_TYP=0, frame 0xA1 with parity bit 1 → Data_Valid pulse at cycle 88, P_DATA=0xA1, par_err=stp_err=0.
- P=16, PAR_EN=1, PAR_TYP=1, frame 0xB2 with parity bit 0 (wrong) → par_err pulse at cycle 176, Data_Valid=0, P_DATA keeps 0xA1.
- P=32, PAR_EN=0, frame 0x5C with stop bit 0 → stp_err pulse at cycle 320, Data_Valid=0.
- P=8: 2-cycle low glitch on idle line → no strobes, FSM back in IDLE by cycle 8. Then two back-to-back frames 0x3C and 0xC3 → Data_Valid at cycles 88 and 176.
- One sample of a data bit inverted in the mid-bit window (P=16, frame 0xFF) → majority vote recovers P_DATA=0xFF.
- RST=0 for one cycle during data bit 4 → all outputs 0 the following cycle, no strobes for that frame. The next frame 0x12 is received correctly.
